// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-port RAM arbiter.
package ram_arb_pkg;

  // Top-level sequencer state: fill the RAM after reset, then arbitrate.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } arb_state_t;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant logic with its last-winner register.
// A lone request is granted outright; under contention the port that did
// not win most recently is granted, so a continuously requesting port gets
// every other cycle.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic last
);

  // last_q = 1 means port 1 won most recently, so port 0 wins the first tie.
  logic last_q;

  // Combinational grant: single request wins, a tie goes to the non-last port.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && req1) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Track the winner of every granted cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (gnt0 || gnt1) begin
      last_q <= gnt1;
    end
  end

  assign last = last_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one registered-read RAM port between two clients.
// After reset an optional fill sequencer writes FILL_VALUE to every address,
// then the port is handed to a round-robin arbiter. Read data comes straight
// from the RAM output one cycle after the grant.
//
// Client handshake: a client raises REQx together with WEx/ADDRx/DIx and
// keeps all of them stable until it sees GNTx high. GNTx is combinational
// and means the access is issued to the RAM in that same cycle, so the
// client may drop or change its request on the following cycle. A granted
// read is answered by a one-cycle VLDx pulse with DOx on the next cycle;
// writes produce no response.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                DEPTH       = 2048,
  parameter logic [DATA_W-1:0] FILL_VALUE  = '0,
  parameter bit                INIT_ENABLE = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] DI0,
  input  logic [DATA_W-1:0] DI1,
  output logic              GNT0,
  output logic              GNT1,
  output logic [DATA_W-1:0] DO0,
  output logic [DATA_W-1:0] DO1,
  output logic              VLD0,
  output logic              VLD1,
  output logic              INIT_DONE,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic              RAM_RST,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_DI,
  input  logic [DATA_W-1:0] RAM_DO,
  output arb_state_t        DBG_STATE
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam arb_state_t        RESET_STATE = INIT_ENABLE ? ST_INIT : ST_ARB;

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;

  logic              arb_en;
  logic              gnt0, gnt1;
  logic              last_winner;

  logic              pend_q, pend_id_q;
  logic              vld0, vld1;
  logic [DATA_W-1:0] do0_q, do1_q;

  // The arbiter only runs in ARB and never while reset is asserted.
  assign arb_en = (state_q == ST_ARB) && !RST;

  rr_arb2 u_rr_arb2 (
    .clk  (CLK),
    .rst  (RST),
    .en   (arb_en),
    .req0 (REQ0),
    .req1 (REQ1),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .last (last_winner)
  );

  // Sequencer state, fill counter and init-done flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RESET_STATE;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Next state plus the RAM port mux: fill writes in INIT, winner in ARB.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    RAM_EN      = 1'b0;
    RAM_WE      = 1'b0;
    RAM_ADDR    = '0;
    RAM_DI      = '0;
    case (state_q)
      ST_INIT: begin
        RAM_EN   = 1'b1;
        RAM_WE   = 1'b1;
        RAM_ADDR = cnt_q;
        RAM_DI   = FILL_VALUE;
        cnt_d    = cnt_q + 1'b1;
        // Leave on the last address so the counter never wraps mid-fill.
        if (cnt_q == LAST_ADDR) begin
          state_d     = ST_ARB;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end
      end
      ST_ARB: begin
        init_done_d = 1'b1;
        if (gnt0) begin
          RAM_EN   = 1'b1;
          RAM_WE   = WE0;
          RAM_ADDR = ADDR0;
          RAM_DI   = DI0;
        end else if (gnt1) begin
          RAM_EN   = 1'b1;
          RAM_WE   = WE1;
          RAM_ADDR = ADDR1;
          RAM_DI   = DI1;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
    // Keep the RAM idle for the whole reset cycle, whatever state_q holds.
    if (RST) begin
      RAM_EN = 1'b0;
      RAM_WE = 1'b0;
    end
  end

  // Remember which port owns the read issued this cycle; writes leave no
  // pending return, so write-first RAM output is never forwarded.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_q    <= 1'b0;
      pend_id_q <= 1'b0;
    end else begin
      pend_q    <= (gnt0 && !WE0) || (gnt1 && !WE1);
      pend_id_q <= gnt1;
    end
  end

  assign vld0 = pend_q && !pend_id_q && !RST;
  assign vld1 = pend_q &&  pend_id_q && !RST;

  // Hold the last returned word per port between valid pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      do0_q <= '0;
      do1_q <= '0;
    end else begin
      if (vld0) do0_q <= RAM_DO;
      if (vld1) do1_q <= RAM_DO;
    end
  end

  // RAM_DO is already registered inside the RAM, so it is passed through.
  assign DO0       = RST ? '0 : (vld0 ? RAM_DO : do0_q);
  assign DO1       = RST ? '0 : (vld1 ? RAM_DO : do1_q);
  assign VLD0      = vld0;
  assign VLD1      = vld1;
  assign GNT0      = gnt0;
  assign GNT1      = gnt1;
  assign INIT_DONE = init_done_q && !RST;
  assign RAM_RST   = 1'b0;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, cycle-level reference model
// of fill / round-robin / read return, directed scenarios plus random traffic.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int              AW    = 11;
  localparam int              DW    = 2;
  localparam int              DEPTH = 2048;
  localparam logic [DW-1:0]   FILL  = 2'b10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] di0 = '0, di1 = '0;
  logic          gnt0, gnt1, vld0, vld1, init_done;
  logic [DW-1:0] do0, do1;
  logic          ram_en, ram_we, ram_rst;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do = '0;
  arb_state_t    dbg_state;

  ram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .FILL_VALUE(FILL), .INIT_ENABLE(1'b1)
  ) dut (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .REQ1(req1), .WE0(we0), .WE1(we1),
    .ADDR0(addr0), .ADDR1(addr1), .DI0(di0), .DI1(di1),
    .GNT0(gnt0), .GNT1(gnt1), .DO0(do0), .DO1(do1),
    .VLD0(vld0), .VLD1(vld1), .INIT_DONE(init_done),
    .RAM_EN(ram_en), .RAM_WE(ram_we), .RAM_RST(ram_rst),
    .RAM_ADDR(ram_addr), .RAM_DI(ram_di), .RAM_DO(ram_do),
    .DBG_STATE(dbg_state)
  );

  // Behavioural block RAM: registered read, write-first output.
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(0, 3));
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_di;
        ram_do        <= ram_di;
      end else begin
        ram_do <= mem[ram_addr];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int            since_rst = 0;   // cycles since reset release
  bit            m_last    = 1'b1; // 1: port 1 won last
  bit            m_pend_v  = 1'b0;
  bit            m_pend_id = 1'b0;
  logic [DW-1:0] m_do0 = '0, m_do1 = '0;
  int            m_w = -1;        // winner of the cycle just evaluated

  // One clock cycle: inputs already set at posedge+1, check at mid-cycle.
  task automatic run_cycle();
    int w;
    bit ev0, ev1;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_di;
    #4;
    w = -1;
    if (rst) begin
      check("rst_gnt0", gnt0, 0);
      check("rst_gnt1", gnt1, 0);
      check("rst_vld0", vld0, 0);
      check("rst_vld1", vld1, 0);
      check("rst_do0", do0, 0);
      check("rst_do1", do1, 0);
      check("rst_init_done", init_done, 0);
      check("rst_ram_en", ram_en, 0);
      check("ram_rst", ram_rst, 0);
      since_rst = 0;
      m_last    = 1'b1;
      m_pend_v  = 1'b0;
      m_do0     = '0;
      m_do1     = '0;
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      ev0 = m_pend_v && !m_pend_id;
      ev1 = m_pend_v &&  m_pend_id;
      check("vld0", vld0, ev0);
      check("vld1", vld1, ev1);
      if (ev0 && exp_q0.size() > 0) m_do0 = exp_q0.pop_front();
      if (ev1 && exp_q1.size() > 0) m_do1 = exp_q1.pop_front();
      check("do0", do0, m_do0);
      check("do1", do1, m_do1);
      if (since_rst < DEPTH) begin
        check("init_state", dbg_state, ST_INIT);
        check("init_gnt0", gnt0, 0);
        check("init_gnt1", gnt1, 0);
        check("init_ram_en", ram_en, 1);
        check("init_ram_we", ram_we, 1);
        check("init_ram_addr", ram_addr, since_rst);
        check("init_ram_di", ram_di, FILL);
        check("init_done_low", init_done, 0);
        ref_mem[since_rst] = FILL;
        since_rst++;
        m_pend_v = 1'b0;
      end else begin
        check("arb_state", dbg_state, ST_ARB);
        check("init_done_high", init_done, 1);
        if (req0 && req1) w = m_last ? 0 : 1;
        else if (req0)    w = 0;
        else if (req1)    w = 1;
        check("gnt0", gnt0, w == 0);
        check("gnt1", gnt1, w == 1);
        check("ram_en", ram_en, w >= 0);
        m_pend_v = 1'b0;
        if (w >= 0) begin
          w_we   = (w == 0) ? we0 : we1;
          w_addr = (w == 0) ? addr0 : addr1;
          w_di   = (w == 0) ? di0 : di1;
          check("ram_we", ram_we, w_we);
          check("ram_addr", ram_addr, w_addr);
          if (w_we) begin
            check("ram_di", ram_di, w_di);
            ref_mem[w_addr] = w_di;
          end else begin
            m_pend_v  = 1'b1;
            m_pend_id = (w == 1);
            if (w == 0) exp_q0.push_back(ref_mem[w_addr]);
            else        exp_q1.push_back(ref_mem[w_addr]);
          end
          m_last = (w == 1);
        end
      end
    end
    m_w = w;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; di0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; di1 = d; end
  endtask

  // Raise a request, hold it until granted (bounded), then drop it.
  task automatic access(input int p, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    set_port(p, 1'b1, w, a, d);
    do begin
      run_cycle();
      n++;
    end while (m_w != p && n < 4000);
    if (m_w != p) check("grant_timeout", 0, 1);
    set_port(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;

    // Port 0 read held through the whole fill; granted on the first ARB cycle.
    access(0, 1'b0, 11'h5A3, '0);
    idle(1);

    // Write 0x7FF on port 1, read it back on port 0 next cycle.
    access(1, 1'b1, 11'h7FF, 2'b11);
    access(0, 1'b0, 11'h7FF, '0);
    idle(1);

    // Only port 1 requesting for 4 cycles.
    set_port(1, 1'b1, 1'b0, 11'h020, '0);
    idle(4);
    set_port(1, 1'b0, 1'b0, '0, '0);
    idle(1);

    // Both ports requesting continuously for 6 cycles.
    set_port(0, 1'b1, 1'b0, 11'h010, '0);
    set_port(1, 1'b1, 1'b0, 11'h020, '0);
    idle(6);
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    idle(2);

    // Random traffic; requests are only changed when idle or just granted.
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (((p == 0) ? !req0 : !req1) || m_w == p) begin
          set_port(p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                               : AW'($urandom_range(0, 7)),
                   DW'($urandom_range(0, 3)));
        end
      end
      run_cycle();
    end
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    idle(2);

    // Reset on the cycle after a port 0 read grant: return dropped, fill restarts.
    access(0, 1'b0, 11'h123, '0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(DEPTH);
    access(0, 1'b0, 11'h123, '0);
    access(1, 1'b0, 11'h004, '0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
